// File: rtl/ppu_issue_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : ppu_issue_if                                               |
// | Bundles the request stream, the core operand/result path and the       |
// | result stream of ppu_issue_stage.                                      |
// |   master : request producer, result consumer and combinational core    |
// |   slave  : the issue stage itself                                      |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface ppu_issue_if #(
  parameter int N       = 16,
  parameter int OP_SIZE = 3,
  parameter int TAG_W   = 4
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_p1;
  logic [N-1:0]       in_p2;
  logic [OP_SIZE-1:0] in_op;
  logic [TAG_W-1:0]   in_tag;
  logic [N-1:0]       core_p1;
  logic [N-1:0]       core_p2;
  logic [OP_SIZE-1:0] core_op;
  logic [N-1:0]       core_pout;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_pout;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_p1, in_p2, in_op, in_tag, out_ready, core_pout,
    input  in_ready, core_p1, core_p2, core_op, out_valid, out_pout, out_tag
  );

  modport slave (
    input  flush, in_valid, in_p1, in_p2, in_op, in_tag, out_ready, core_pout,
    output in_ready, core_p1, core_p2, core_op, out_valid, out_pout, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/ppu_issue_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : ppu_issue_stage                                            |
// | Issue/retire stage around the combinational posit core. Requests       |
// | (p1, p2, op, tag) are queued in a DEPTH-entry FIFO whose head drives   |
// | the core; the core result is captured into a registered valid/ready   |
// | output, one operation per cycle.                                       |
// | Ports:                                                                 |
// |   clk, rst   clock and synchronous active-high reset                   |
// |   bus        ppu_issue_if.slave: flush, in_* request stream,           |
// |              core_* operand/result path, out_* result stream           |
// |   occupancy  current FIFO count            (PPU_ISSUE_STATS_EN only)   |
// |   retired    results handed out, wrapping  (PPU_ISSUE_STATS_EN only)   |
// | Optional feature macro: PPU_ISSUE_STATS_EN                             |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
module ppu_issue_stage #(
  parameter int N       = 16,
  parameter int OP_SIZE = 3,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input wire           clk,
  input wire           rst,
  ppu_issue_if.slave   bus
`ifdef PPU_ISSUE_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            retired
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [N-1:0]       r_p1_mem  [DEPTH];
  logic [N-1:0]       r_p2_mem  [DEPTH];
  logic [OP_SIZE-1:0] r_op_mem  [DEPTH];
  logic [TAG_W-1:0]   r_tag_mem [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_out_valid;
  logic [N-1:0]       r_out_pout;
  logic [TAG_W-1:0]   r_out_tag;

  logic w_in_ready;
  logic w_push;
  logic w_pop;

  // in_ready looks only at the registered count, so a full FIFO refuses a
  // push even in a cycle where it also pops; this keeps out_ready off the
  // upstream ready path.
  assign w_in_ready = (r_count != c_CNT_W'(DEPTH));
  assign w_push     = bus.in_valid & w_in_ready;
  // The head may move into the output register when it is empty or being
  // drained in this same cycle.
  assign w_pop      = (r_count != '0) & (~r_out_valid | bus.out_ready);

  assign bus.in_ready  = w_in_ready;
  assign bus.core_p1   = r_p1_mem[r_rd_ptr];
  assign bus.core_p2   = r_p2_mem[r_rd_ptr];
  assign bus.core_op   = r_op_mem[r_rd_ptr];
  assign bus.out_valid = r_out_valid;
  assign bus.out_pout  = r_out_pout;
  assign bus.out_tag   = r_out_tag;

  // Storage needs no reset: entries are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_p1_mem[r_wr_ptr]  <= bus.in_p1;
      r_p2_mem[r_wr_ptr]  <= bus.in_p2;
      r_op_mem[r_wr_ptr]  <= bus.in_op;
      r_tag_mem[r_wr_ptr] <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_pout  <= '0;
      r_out_tag   <= '0;
    end else if (bus.flush) begin
      // Result payload is left in place; only the valid is dropped.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_out_pout  <= bus.core_pout;
        r_out_tag   <= r_tag_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else if (r_out_valid & bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef PPU_ISSUE_STATS_EN
  logic [31:0] r_retired;

  // Counts every completed output handshake; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (r_out_valid & bus.out_ready) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign occupancy = r_count;
  assign retired   = r_retired;
`endif

endmodule
`default_nettype wire
